// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: register indices, finisher
// commands, FSM state encodings and the watchdog exit code.
// Latency: n/a (definitions only).  Backpressure: n/a.
package sys_ctrl_pkg;

    // Register map (word index on i_addr)
    localparam logic [2:0] REG_FINISHER = 3'd0;
    localparam logic [2:0] REG_CYCLE_LO = 3'd1;
    localparam logic [2:0] REG_CYCLE_HI = 3'd2;
    localparam logic [2:0] REG_SCRATCH  = 3'd3;
    localparam logic [2:0] REG_WDOG     = 3'd4;

    // Finisher commands (low half of the finisher write)
    localparam logic [15:0] CMD_PASS   = 16'h5555;
    localparam logic [15:0] CMD_FAIL   = 16'h3333;
    localparam logic [15:0] CMD_REBOOT = 16'h7777;

    // Exit code reported when the watchdog forces a reboot
    localparam logic [15:0] WDOG_EXIT_CODE = 16'hDEAD;

    // FSM state encodings; these values are visible in the finisher read
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Finisher write word layout
    typedef struct packed {
        logic [15:0] code;
        logic [15:0] cmd;
    } fin_word_t;

    function automatic logic cmd_valid(input logic [15:0] cmd);
        return (cmd == CMD_PASS) || (cmd == CMD_FAIL) || (cmd == CMD_REBOOT);
    endfunction

endpackage

// File: rtl/sys_ctrl_wdog.sv
// Watchdog: reloadable down-counter that pulses o_expire on the 1->0 step.
// Latency: expire pulse is combinational in the cycle the counter holds 1.
// Backpressure: none; a reload write always takes effect.
//
// Ports:
//   clk, reset  clock, synchronous active-low reset
//   i_wr        reload strobe (accepted bus write to the watchdog register)
//   i_wdata     reload value; 0 disables the watchdog
//   i_run       counting enable (controller is in RUN)
//   o_expire    one-cycle pulse when the counter steps from 1 to 0
//   o_reload    last value written, for read-back
module sys_ctrl_wdog #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_run,
    output logic             o_expire,
    output logic [WIDTH-1:0] o_reload
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q;

    // A reload in the same cycle supersedes the expiry step.
    assign o_expire = i_run && !i_wr && (cnt_q == WIDTH'(1));
    assign o_reload = reload_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_wr) begin
            cnt_d = i_wdata;
        end else if (i_run && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (i_wr) begin
                reload_q <= i_wdata;
            end
        end
    end

endmodule

// File: rtl/sys_ctrl.sv
// System controller: finisher (pass/fail/reboot), 64-bit cycle counter, scratch.
// Latency: bus ack and read data one cycle after i_stb is sampled.
// Backpressure: i_stb held until o_ack; at most one access every two cycles.
//
// Optional watchdog enabled by defining SYS_CTRL_WDOG_EN (adds WDOG_WIDTH and
// register 4); without it register 4 reads 0 and ignores writes.
//
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   i_stb/i_we/i_addr/i_wdata  bus request, direction, word index, write data
//   o_ack/o_rdata           one-cycle acknowledge, read data valid with ack
//   o_close_file            flush request to file/console device (in FLUSH)
//   i_close_done            flush complete
//   o_shutdown/o_exit_code  sticky power-off indication and its exit code
//   o_core_reset_n          active-low reset to the CPU core (low in HOLD)
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int FLUSH_TIMEOUT = 1024
`ifdef SYS_CTRL_WDOG_EN
    ,
    parameter int WDOG_WIDTH    = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [2:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_close_file,
    input  logic        i_close_done,
    output logic        o_shutdown,
    output logic [15:0] o_exit_code,
    output logic        o_core_reset_n
);

    // One timer serves both FLUSH timeout and HOLD duration.
    localparam int TMR_MAX = (FLUSH_TIMEOUT > RESET_CYCLES) ? FLUSH_TIMEOUT : RESET_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic             ack_q;
    logic [31:0]      rdata_q;
    logic [63:0]      cycle_q;
    logic [31:0]      cycle_hi_q;
    logic [31:0]      scratch_q;
    logic [1:0]       state_q, state_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [15:0]      code_q, code_d;
    logic [15:0]      exit_q, exit_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic             acc;
    logic             wr_acc;
    logic             rd_acc;
    logic             fin_go;
    fin_word_t        fin_wr;
    logic [31:0]      rd_mux;
    logic             wdog_expire;
    logic [31:0]      wdog_rdata;

    assign acc    = i_stb && !ack_q;
    assign wr_acc = acc && i_we;
    assign rd_acc = acc && !i_we;
    assign fin_wr = fin_word_t'(i_wdata);
    // Finisher commands only start a sequence from RUN; elsewhere acked only.
    assign fin_go = wr_acc && (i_addr == REG_FINISHER) && cmd_valid(fin_wr.cmd)
                    && (state_q == ST_RUN);

`ifdef SYS_CTRL_WDOG_EN
    logic [WDOG_WIDTH-1:0] wdog_reload;

    sys_ctrl_wdog #(
        .WIDTH (WDOG_WIDTH)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .i_wr     (wr_acc && (i_addr == REG_WDOG)),
        .i_wdata  (WDOG_WIDTH'(i_wdata)),
        .i_run    (state_q == ST_RUN),
        .o_expire (wdog_expire),
        .o_reload (wdog_reload)
    );

    assign wdog_rdata = 32'(wdog_reload);
`else
    assign wdog_expire = 1'b0;
    assign wdog_rdata  = 32'd0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (i_addr)
            REG_FINISHER: rd_mux = {14'd0, state_q, exit_q};
            REG_CYCLE_LO: rd_mux = cycle_q[31:0];
            REG_CYCLE_HI: rd_mux = cycle_hi_q;
            REG_SCRATCH:  rd_mux = scratch_q;
            REG_WDOG:     rd_mux = wdog_rdata;
            default:      rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        code_d  = code_q;
        exit_d  = exit_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_RUN: begin
                // A finisher write outranks a watchdog expiry in the same cycle.
                if (fin_go) begin
                    state_d = ST_FLUSH;
                    cmd_d   = fin_wr.cmd;
                    code_d  = (fin_wr.cmd == CMD_PASS) ? 16'h0000 : fin_wr.code;
                    tmr_d   = '0;
                end else if (wdog_expire) begin
                    state_d = ST_FLUSH;
                    cmd_d   = CMD_REBOOT;
                    code_d  = WDOG_EXIT_CODE;
                    tmr_d   = '0;
                end
            end
            ST_FLUSH: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (i_close_done || (tmr_q == TMR_W'(FLUSH_TIMEOUT - 1))) begin
                    state_d = (cmd_q == CMD_REBOOT) ? ST_HOLD : ST_OFF;
                    exit_d  = code_q;
                    tmr_d   = '0;
                end
            end
            ST_HOLD: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    tmr_d   = '0;
                end
            end
            default: begin
                // ST_OFF is terminal until reset.
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            cycle_q    <= 64'd0;
            cycle_hi_q <= 32'd0;
            scratch_q  <= 32'd0;
            state_q    <= ST_RUN;
            cmd_q      <= 16'd0;
            code_q     <= 16'd0;
            exit_q     <= 16'd0;
            tmr_q      <= '0;
        end else begin
            ack_q   <= acc;
            rdata_q <= rd_acc ? rd_mux : 32'd0;
            cycle_q <= cycle_q + 64'd1;
            // Reading the low word freezes the high word so a later HI read
            // pairs with it even if a carry happens in between.
            if (rd_acc && (i_addr == REG_CYCLE_LO)) begin
                cycle_hi_q <= cycle_q[63:32];
            end
            if (wr_acc && (i_addr == REG_SCRATCH)) begin
                scratch_q <= i_wdata;
            end
            state_q <= state_d;
            cmd_q   <= cmd_d;
            code_q  <= code_d;
            exit_q  <= exit_d;
            tmr_q   <= tmr_d;
        end
    end

    assign o_ack          = ack_q;
    assign o_rdata        = rdata_q;
    assign o_close_file   = (state_q == ST_FLUSH);
    assign o_shutdown     = (state_q == ST_OFF);
    assign o_exit_code    = exit_q;
    assign o_core_reset_n = (state_q != ST_HOLD);

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: reset values, bus map, finisher pass/fail/reboot,
// flush timeout, cycle counter shadowing across a carry, and the optional watchdog.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_sys_ctrl;

    logic        clk;
    logic        reset;
    logic        i_stb;
    logic        i_we;
    logic [2:0]  i_addr;
    logic [31:0] i_wdata;
    logic        o_ack;
    logic [31:0] o_rdata;
    logic        o_close_file;
    logic        i_close_done;
    logic        o_shutdown;
    logic [15:0] o_exit_code;
    logic        o_core_reset_n;

    int n_assert;
    int n_fail;

    sys_ctrl #(
        .RESET_CYCLES  (16),
        .FLUSH_TIMEOUT (1024)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_stb          (i_stb),
        .i_we           (i_we),
        .i_addr         (i_addr),
        .i_wdata        (i_wdata),
        .o_ack          (o_ack),
        .o_rdata        (o_rdata),
        .o_close_file   (o_close_file),
        .i_close_done   (i_close_done),
        .o_shutdown     (o_shutdown),
        .o_exit_code    (o_exit_code),
        .o_core_reset_n (o_core_reset_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus access: the request is accepted at the next edge and ack/rdata
    // are visible right after it. Callers leave at least one idle edge between
    // accesses.
    task automatic bus(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        i_stb   = 1'b1;
        i_we    = we;
        i_addr  = addr;
        i_wdata = wd;
        tick();
        check("ack", o_ack, 1);
        rd      = o_rdata;
        i_stb   = 1'b0;
        i_we    = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lowcnt;

        n_assert     = 0;
        n_fail       = 0;
        reset        = 1'b0;
        i_stb        = 1'b0;
        i_we         = 1'b0;
        i_addr       = 3'd0;
        i_wdata      = 32'd0;
        i_close_done = 1'b0;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst_ack",      o_ack, 0);
        check("rst_rdata",    o_rdata, 0);
        check("rst_close",    o_close_file, 0);
        check("rst_shutdown", o_shutdown, 0);
        check("rst_exit",     o_exit_code, 0);
        check("rst_core_rst", o_core_reset_n, 1);

        // Cycle counter reads 0 on the first edge out of reset, then +2 per access pair
        reset = 1'b1;
        bus(1'b0, 3'd1, 32'd0, rd);
        check("cycle_first", rd, 32'd0);
        tick();
        check("ack_drop", o_ack, 0);
        bus(1'b0, 3'd1, 32'd0, rd);
        check("cycle_2", rd, 32'd2);
        tick();
        bus(1'b0, 3'd1, 32'd0, rd);
        check("cycle_4", rd, 32'd4);
        tick();

        // Scratch, unmapped addresses, register 4, invalid finisher command
        bus(1'b1, 3'd3, 32'h1234_5678, rd);
        tick();
        bus(1'b0, 3'd3, 32'd0, rd);
        check("scratch_rd", rd, 32'h1234_5678);
        tick();
        bus(1'b1, 3'd6, 32'hFFFF_FFFF, rd);
        tick();
        bus(1'b0, 3'd6, 32'd0, rd);
        check("unmapped6", rd, 32'd0);
        tick();
        bus(1'b0, 3'd5, 32'd0, rd);
        check("unmapped5", rd, 32'd0);
        tick();
        bus(1'b0, 3'd4, 32'd0, rd);
        check("reg4_idle", rd, 32'd0);
        tick();
        bus(1'b1, 3'd0, 32'h0000_1234, rd);
        tick();
        check("badcmd_close", o_close_file, 0);
        bus(1'b0, 3'd0, 32'd0, rd);
        check("badcmd_fin", rd, 32'd0);
        tick();

        // Pass: close_done pulsed five cycles after the write
        bus(1'b1, 3'd0, 32'h0000_5555, rd);
        check("pass_close_on", o_close_file, 1);
        repeat (4) tick();
        check("pass_close_hold", o_close_file, 1);
        check("pass_not_off", o_shutdown, 0);
        i_close_done = 1'b1;
        tick();
        i_close_done = 1'b0;
        check("pass_close_off", o_close_file, 0);
        check("pass_shutdown", o_shutdown, 1);
        check("pass_exit", o_exit_code, 16'h0000);
        bus(1'b0, 3'd0, 32'd0, rd);
        check("pass_fin_rd", rd, 32'h0002_0000);
        tick();
        // Finisher ignored in OFF; other registers remain accessible
        bus(1'b1, 3'd0, 32'h002A_3333, rd);
        tick();
        check("off_exit_sticky", o_exit_code, 16'h0000);
        check("off_shutdown", o_shutdown, 1);
        check("off_close", o_close_file, 0);
        bus(1'b0, 3'd3, 32'd0, rd);
        check("off_scratch", rd, 32'h1234_5678);
        tick();

        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst2_shutdown", o_shutdown, 0);
        check("rst2_exit", o_exit_code, 0);

        // Fail with close_done tied low: flush times out after 1024 cycles
        bus(1'b1, 3'd0, 32'h002A_3333, rd);
        repeat (1023) tick();
        check("to_close_last", o_close_file, 1);
        check("to_not_off", o_shutdown, 0);
        tick();
        check("to_close_off", o_close_file, 0);
        check("to_shutdown", o_shutdown, 1);
        check("to_exit", o_exit_code, 16'h002A);
        bus(1'b0, 3'd0, 32'd0, rd);
        check("to_fin_rd", rd, 32'h0002_002A);
        tick();

        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus(1'b0, 3'd3, 32'd0, rd);
        check("rst3_scratch", rd, 32'd0);
        tick();

        // Reboot: core reset low for exactly 16 cycles, scratch preserved
        bus(1'b1, 3'd3, 32'hCAFE_F00D, rd);
        tick();
        bus(1'b1, 3'd0, 32'h0000_7777, rd);
        check("rb_close_on", o_close_file, 1);
        i_close_done = 1'b1;
        tick();
        i_close_done = 1'b0;
        check("rb_close_off", o_close_file, 0);
        check("rb_core_low", o_core_reset_n, 0);
        lowcnt = 0;
        while (!o_core_reset_n && lowcnt < 40) begin
            lowcnt++;
            tick();
        end
        check("rb_low_cycles", lowcnt, 16);
        check("rb_shutdown", o_shutdown, 0);
        bus(1'b0, 3'd0, 32'd0, rd);
        check("rb_fin_rd", rd, 32'd0);
        tick();
        bus(1'b0, 3'd3, 32'd0, rd);
        check("rb_scratch", rd, 32'hCAFE_F00D);
        tick();

        // Reset asserted mid-HOLD releases the core reset at once
        bus(1'b1, 3'd0, 32'h0000_7777, rd);
        i_close_done = 1'b1;
        tick();
        i_close_done = 1'b0;
        repeat (3) tick();
        check("hold_mid_low", o_core_reset_n, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("hold_rst_core", o_core_reset_n, 1);
        check("hold_rst_close", o_close_file, 0);
        tick();
        check("hold_rst_run", o_core_reset_n, 1);

        // Cycle counter carry: HI returns the value frozen at the LO read
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
        #2;
        release dut.cycle_q;
        bus(1'b0, 3'd1, 32'd0, rd);
        check("carry_lo_pre", rd, 32'hFFFF_FFFE);
        tick();
        bus(1'b0, 3'd1, 32'd0, rd);
        check("carry_lo_post", rd, 32'h0000_0000);
        repeat (10) tick();
        bus(1'b0, 3'd2, 32'd0, rd);
        check("carry_hi", rd, 32'h0000_0001);
        tick();
        bus(1'b0, 3'd1, 32'd0, rd);
        check("carry_lo_later", rd, 32'h0000_000D);
        tick();

`ifdef SYS_CTRL_WDOG_EN
        // Watchdog loaded with 20 and never kicked: reboot starts 20 cycles later
        bus(1'b1, 3'd4, 32'd20, rd);
        repeat (19) tick();
        check("wd_not_yet", o_close_file, 0);
        tick();
        check("wd_flush", o_close_file, 1);
        i_close_done = 1'b1;
        tick();
        i_close_done = 1'b0;
        check("wd_hold", o_core_reset_n, 0);
        repeat (16) tick();
        check("wd_release", o_core_reset_n, 1);
        bus(1'b0, 3'd0, 32'd0, rd);
        check("wd_exit_code", rd, 32'h0000_DEAD);
        tick();
        bus(1'b0, 3'd4, 32'd0, rd);
        check("wd_reload_rd", rd, 32'd20);
        repeat (30) tick();
        check("wd_disarmed", o_close_file, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
